mem_write_data_encoder: RTL and testbench
=========================================

Name: mem_write_data_encoder

Overview:
- Store-path counterpart of the memory read-data decoder. Takes a register value, byte address and access size from the core.
- Builds big-endian lane-aligned write data and byte enables, then drives a single-outstanding req/ack write transaction to data memory.
- Sits between the MEM-stage store logic and the data-memory port.
- Reports completion, size errors, misalignment errors and ack timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles mem_req stays high without mem_ack before abort; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from core
- st_ready  out  1  encoder can accept a store
- st_addr  in  32  byte address of store
- st_data  in  32  register data; the store operand sits in the LSBs
- st_ds  in  2  size: 00 word, 01 half-word, 10 byte, 11 invalid
- st_done  out  1  one-cycle pulse: store acknowledged by memory
- st_err  out  1  one-cycle pulse: store aborted
- st_err_code  out  2  01 invalid size, 10 misaligned, 11 timeout; valid with st_err
- mem_req  out  1  write request, held until ack
- mem_addr  out  32  word-aligned address {st_addr[31:2],2'b00}
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte enables; bit3 = bits 31:24
- mem_ack  in  1  memory accepted the write

Behaviour:
- Reset values: all outputs 0, except st_ready = 1 (IDLE). Counter = 0.
- States: IDLE, REQ.
- st_ready = (state == IDLE). A store is accepted on a rising edge with st_valid && st_ready.
- Encoding on accept; ofs = st_addr[1:0]; big-endian; non-enabled lanes are driven 0:
  - Word: wdata = st_data; be = 1111.
  - Half, ofs[1] = 0: wdata = {st_data[15:0],16'h0}; be = 1100.
  - Half, ofs[1] = 1: wdata = {16'h0,st_data[15:0]}; be = 0011.
  - Byte, ofs 0/1/2/3: st_data[7:0] placed in bits 31:24 / 23:16 / 15:8 / 7:0; be = 1000 / 0100 / 0010 / 0001.
- Accept with valid size: registers mem_addr, mem_wdata and mem_be, sets mem_req = 1, goes to REQ. mem_req rises the cycle after the accept edge (latency 1).
- Accept with st_ds = 11: no request; st_err = 1, code 01, the cycle after accept; state stays IDLE.
- REQ:
  - mem_addr, mem_wdata and mem_be stay stable while mem_req is high.
  - Counter increments each cycle mem_req is high and mem_ack is low.
  - If mem_ack is sampled high: mem_req = 0, st_done = 1 for one cycle, go to IDLE, counter cleared.
- Timeout (TIMEOUT_CYCLES > 0): with the counter at TIMEOUT_CYCLES-1 and no ack, mem_req = 0, st_err = 1 with code 11, go to IDLE. If ack and timeout occur in the same cycle, ack wins.
- Back-to-back: st_ready is high in the cycle st_done pulses, so a new store can be accepted then. Maximum throughput is one store per 2 cycles with zero-wait ack.
- mem_ack while in IDLE is ignored.
- rst in REQ: the transaction is dropped, mem_req = 0 at the next edge, and no st_done or st_err is produced.
- st_done and st_err are never high together.

Optional Feature:
- Macro: MEM_WRITE_MISALIGN_TRAP_EN.
- Defined: a word store with ofs != 00, or a half store with ofs[0] = 1, is rejected. No mem_req is issued; st_err = 1 with code 10 the cycle after accept; state stays IDLE.
- Undefined: word stores ignore ofs entirely, and half stores ignore ofs[0] (offset 01 maps like 00, 11 like 10). This matches the read decoder, and code 10 is never produced.

Test Plan:
- Byte store: st_addr = 0x1002, st_data = 0x000000A5, ds = 10 -> next cycle mem_req = 1, mem_addr = 0x1000, mem_wdata = 0x0000A500, be = 0010. Ack 3 cycles later -> st_done pulse.
- Half store: addr = 0x2000, data = 0x1234BEEF, ds = 01 -> wdata = 0xBEEF0000, be = 1100. Then addr 0x2002 -> wdata = 0x0000BEEF, be = 0011. Both complete back-to-back with ack held high; st_done pulses two cycles apart.
- Word store with mem_ack low: TIMEOUT_CYCLES = 4 -> mem_req high exactly 4 cycles, then st_err with code 11 and st_ready = 1. Repeat with ack arriving on the 4th cycle -> st_done, no st_err.
- ds = 11, data = 0xFFFFFFFF -> no mem_req; st_err with code 01 one cycle after accept.
- Misaligned half, addr = 0x3001, data = 0x00007777: with the macro -> st_err, code 10, no mem_req. Without the macro -> wdata = 0x77770000, be = 1100.
- rst asserted in the 2nd cycle of REQ -> next edge mem_req = 0 and all outputs at reset values; a later ack causes no st_done.

Source files
------------

// File: rtl/mem_write_data_encoder.sv
// rtl/mem_write_data_encoder.sv - big-endian store lane encoder with single-outstanding req/ack write port
// Optional misalignment trap: define MEM_WRITE_MISALIGN_TRAP_EN.
module mem_write_data_encoder #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_ds,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  st_err_code,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ofs;
  logic [31:0]      enc_wdata;
  logic [3:0]       enc_be;
  logic             misalign;

  assign ofs = st_addr[1:0];

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    enc_wdata = 32'h0;
    enc_be    = 4'b0000;
    case (st_ds)
      2'b00: begin
        enc_wdata = st_data;
        enc_be    = 4'b1111;
      end
      2'b01: begin
        if (ofs[1]) begin
          enc_wdata = {16'h0, st_data[15:0]};
          enc_be    = 4'b0011;
        end else begin
          enc_wdata = {st_data[15:0], 16'h0};
          enc_be    = 4'b1100;
        end
      end
      2'b10: begin
        case (ofs)
          2'd0: begin enc_wdata = {st_data[7:0], 24'h0};        enc_be = 4'b1000; end
          2'd1: begin enc_wdata = {8'h0, st_data[7:0], 16'h0};  enc_be = 4'b0100; end
          2'd2: begin enc_wdata = {16'h0, st_data[7:0], 8'h0};  enc_be = 4'b0010; end
          default: begin enc_wdata = {24'h0, st_data[7:0]};     enc_be = 4'b0001; end
        endcase
      end
      default: begin
        enc_wdata = 32'h0;
        enc_be    = 4'b0000;
      end
    endcase
  end

`ifdef MEM_WRITE_MISALIGN_TRAP_EN
  assign misalign = ((st_ds == 2'b00) && (ofs != 2'b00)) ||
                    ((st_ds == 2'b01) && ofs[0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      st_ready    <= 1'b1;
      st_done     <= 1'b0;
      st_err      <= 1'b0;
      st_err_code <= 2'b00;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_be      <= 4'b0000;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            if (st_ds == 2'b11) begin
              st_err      <= 1'b1;
              st_err_code <= 2'b01;
            end else if (misalign) begin
              st_err      <= 1'b1;
              st_err_code <= 2'b10;
            end else begin
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= enc_wdata;
              mem_be    <= enc_be;
              mem_req   <= 1'b1;
              st_ready  <= 1'b0;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            st_done  <= 1'b1;
            st_ready <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else if (TO_EN && (cnt == TO_LAST)) begin
            mem_req     <= 1'b0;
            st_err      <= 1'b1;
            st_err_code <= 2'b11;
            st_ready    <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          st_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_data_encoder.sv
// tb/tb_mem_write_data_encoder.sv - randomized self-checking bench for mem_write_data_encoder
module tb_mem_write_data_encoder;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_ds;
  logic        st_done;
  logic        st_err;
  logic [1:0]  st_err_code;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  mem_write_data_encoder #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_ds(st_ds),
    .st_done(st_done), .st_err(st_err), .st_err_code(st_err_code),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte lanes numbered big-endian, lane k occupies bits 31-8k:24-8k.
  function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] ds, output logic [31:0] wd,
                                output logic [3:0] be, output logic [1:0] ecode);
    int o;
    o     = int'(addr[1:0]);
    wd    = 32'h0;
    be    = 4'h0;
    ecode = 2'b00;
    if (ds == 2'd3) begin
      ecode = 2'b01;
    end else if (ds == 2'd0) begin
`ifdef MEM_WRITE_MISALIGN_TRAP_EN
      if (o != 0) ecode = 2'b10;
`endif
      wd = data;
      be = 4'hF;
    end else if (ds == 2'd1) begin
`ifdef MEM_WRITE_MISALIGN_TRAP_EN
      if (o % 2 == 1) ecode = 2'b10;
`endif
      o  = (o / 2) * 2;
      wd = (data & 32'hFFFF) << (8 * (2 - o));
      be = 4'b0011 << (2 - o);
    end else begin
      wd = (data & 32'hFF) << (8 * (3 - o));
      be = 4'b0001 << (3 - o);
    end
  endfunction

  // ack_cyc: the req-high cycle (1-based) in which mem_ack is presented; > TO means never.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] ds, input int ack_cyc);
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  ecode;
    model(addr, data, ds, wd, be, ecode);
    check("ready_before_accept", st_ready, 1);
    st_valid = 1'b1; st_addr = addr; st_data = data; st_ds = ds;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    check("done_idle_after_accept", st_done, 0);
    if (ecode != 2'b00) begin
      check("err_pulse", st_err, 1);
      check("err_code", st_err_code, ecode);
      check("no_req_on_err", mem_req, 0);
      check("ready_on_err", st_ready, 1);
      return;
    end
    check("err_idle_after_accept", st_err, 0);
    for (int c = 1; c <= TO + 2; c++) begin
      check("req_high", mem_req, 1);
      check("ready_low", st_ready, 0);
      check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check("mem_wdata", mem_wdata, wd);
      check("mem_be", mem_be, be);
      mem_ack = (c == ack_cyc);
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      if (c == ack_cyc) begin
        check("done_pulse", st_done, 1);
        check("no_err_on_done", st_err, 0);
        check("req_drop_done", mem_req, 0);
        check("ready_after_done", st_ready, 1);
        return;
      end
      if (c == TO) begin
        check("timeout_err", st_err, 1);
        check("timeout_code", st_err_code, 2'b11);
        check("no_done_on_timeout", st_done, 0);
        check("req_drop_timeout", mem_req, 0);
        check("ready_after_timeout", st_ready, 1);
        return;
      end
      check("no_pulse_while_req", {st_done, st_err}, 0);
    end
    check("store_bounded", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, st_ready, 1);
    check({tag, "_done"}, st_done, 0);
    check({tag, "_err"}, st_err, 0);
    check({tag, "_code"}, st_err_code, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_be"}, mem_be, 0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = 0; st_data = 0; st_ds = 0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the test plan
    do_store(32'h0000_1002, 32'h0000_00A5, 2'b10, 3);
    do_store(32'h0000_2000, 32'h1234_BEEF, 2'b01, 1);
    do_store(32'h0000_2002, 32'h1234_BEEF, 2'b01, 1);
    do_store(32'h0000_4000, 32'hDEAD_BEEF, 2'b00, TO + 1);
    do_store(32'h0000_4000, 32'hDEAD_BEEF, 2'b00, TO);
    do_store(32'h0000_5000, 32'hFFFF_FFFF, 2'b11, 1);
    do_store(32'h0000_3001, 32'h0000_7777, 2'b01, 1);
    do_store(32'h0000_3003, 32'hCAFE_F00D, 2'b00, 2);

    // Ack while idle must not produce a pulse
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_ignored", {st_done, st_err, mem_req}, 0);

    // Reset in the second REQ cycle drops the transaction
    st_valid = 1'b1; st_addr = 32'h0000_6004; st_data = 32'h0102_0304; st_ds = 2'b00;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    check("rst_case_req", mem_req, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_in_req");
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_no_done", {st_done, st_err, mem_req}, 0);
    @(negedge clk);

    // Randomized stores
    for (int i = 0; i < 60; i++) begin
      do_store($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, TO + 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
